// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a 64-bit operand stack with sticky trap/halt.
// Define STACK_ARBITER_RR_EN for round-robin arbitration; fixed priority (req0 first) otherwise.
module stack_arbiter #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [1:0]               op0,
    input  logic [1:0]               op1,
    input  logic [63:0]              wdata0,
    input  logic [63:0]              wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [63:0]              rdata,
    output logic                     err,
    output logic [63:0]              result,
    output logic                     result_empty,
    output logic [2:0]               trap,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] OpPeek  = 2'b00;
    localparam logic [1:0] OpPush  = 2'b01;
    localparam logic [1:0] OpPop   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StAck, StHalt} state_e;

    state_e         state_q, state_d;
    logic           win_q;
    logic [1:0]     op_q;
    logic [63:0]    wdata_q;
    logic           prio_q;
    logic [CW-1:0]  count_q;
    logic [63:0]    result_q;
    logic           result_empty_q;
    logic [2:0]     trap_q;
    logic           ack0_q, ack1_q, err_q;
    logic [63:0]    rdata_q;
    logic [63:0]    mem [DEPTH];

    logic           grant_any;
    logic           grant_win;
    logic           full, empty;
    logic [AW-1:0]  top_idx, next_idx, push_idx;
    logic           exec_err;

    assign grant_any = req0 | req1;
`ifdef STACK_ARBITER_RR_EN
    // On a tie the requester not granted last wins.
    assign grant_win = (req0 && req1) ? prio_q : !req0;
`else
    assign grant_win = !req0;
`endif

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_idx = AW'(count_q);
    assign top_idx  = AW'(count_q - CW'(1));
    assign next_idx = AW'(count_q - CW'(2));

    always_comb begin
        exec_err = 1'b0;
        case (op_q)
            OpPush:        exec_err = full;
            OpPop, OpPeek: exec_err = empty;
            default:       exec_err = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (grant_any) state_d = StExec;
            StExec: state_d = StAck;
            StAck:  state_d = err_q ? StHalt : StIdle;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == StExec && op_q == OpPush && !full) begin
            mem[push_idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            win_q          <= 1'b0;
            op_q           <= OpPeek;
            wdata_q        <= '0;
            prio_q         <= 1'b0;
            count_q        <= '0;
            result_q       <= '0;
            result_empty_q <= 1'b1;
            trap_q         <= 3'd0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            state_q <= state_d;
            // Completion outputs are single-cycle pulses.
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        win_q   <= grant_win;
                        op_q    <= grant_win ? op1 : op0;
                        wdata_q <= grant_win ? wdata1 : wdata0;
                        prio_q  <= !grant_win;
                    end
                end
                StExec: begin
                    ack0_q <= !win_q;
                    ack1_q <= win_q;
                    err_q  <= exec_err;
                    case (op_q)
                        OpPush: begin
                            if (full) begin
                                trap_q <= 3'd1;
                            end else begin
                                count_q        <= count_q + CW'(1);
                                result_q       <= wdata_q;
                                result_empty_q <= 1'b0;
                            end
                        end
                        OpPop: begin
                            if (empty) begin
                                trap_q <= 3'd2;
                            end else begin
                                rdata_q        <= mem[top_idx];
                                count_q        <= count_q - CW'(1);
                                result_q       <= (count_q > CW'(1)) ? mem[next_idx] : '0;
                                result_empty_q <= (count_q == CW'(1));
                            end
                        end
                        OpPeek: begin
                            if (empty) trap_q <= 3'd2;
                            else       rdata_q <= mem[top_idx];
                        end
                        default: begin
                            count_q        <= '0;
                            result_q       <= '0;
                            result_empty_q <= 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign result       = result_q;
    assign result_empty = result_empty_q;
    assign trap         = trap_q;
    assign count        = count_q;

endmodule
